// File: rtl/pdm_cic_sched.sv
// Purpose: PDM clock and sample timing plus the comb-stage channel sequencer for the 8-channel CIC decimator.
// Latency: bits/sample_stb/hop are registered one clock after the capture edge; comb_stb follows hop by one clock.
// Backpressure: the comb datapath throttles via comb_done; the sequencer waits indefinitely, and a hop that lands mid-sequence sets sticky overrun.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   enable                 runs the PDM clock divider and sampling
//   clr_ovr                clears the sticky overrun flag
//   din[NCH]               raw PDM bits from the microphones
//   clk_out_pdm            PDM microphone clock, 50% duty, period CLK_DIV
//   sample_stb, bits[NCH]  one-cycle strobe with the registered sample set
//   hop                    one-cycle decimation boundary pulse
//   comb_stb, comb_ch      per-channel request to the shared comb datapath
//   comb_done              comb datapath completion for the current channel
//   busy, overrun          sequence-in-progress and sticky overrun status

module pdm_cic_sched #(
  parameter int CLK_DIV = 8,
  parameter int DECIM   = 64,
  parameter int NCH     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clr_ovr,
  input  logic [NCH-1:0]          din,
  output logic                    clk_out_pdm,
  output logic                    sample_stb,
  output logic [NCH-1:0]          bits,
  output logic                    hop,
  output logic                    comb_stb,
  output logic [$clog2(NCH)-1:0]  comb_ch,
  input  logic                    comb_done,
  output logic                    busy,
  output logic                    overrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int DEC_W = $clog2(DECIM);
  localparam int CH_W  = $clog2(NCH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  logic [DIV_W-1:0] div_cnt;
  logic [DEC_W-1:0] dec_cnt;
  state_t           state;
  logic             capture;

  // The last clock of the low phase is the capture point: the microphone has
  // had the whole low half-period to settle its data.
  assign capture = enable && (div_cnt == DIV_LAST);

  // Clock divider, sampling and decimation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      dec_cnt     <= '0;
      clk_out_pdm <= 1'b0;
      sample_stb  <= 1'b0;
      bits        <= '0;
      hop         <= 1'b0;
    end else begin
      if (!enable || capture) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      // Gating with enable parks the mic clock low while stopped.
      clk_out_pdm <= enable && (div_cnt < DIV_HALF);
      sample_stb  <= capture;
      hop         <= capture && (dec_cnt == DEC_LAST);

      if (capture) begin
        bits <= din;
        // dec_cnt only advances on captures, so pausing enable keeps the
        // decimation phase intact.
        if (dec_cnt == DEC_LAST) begin
          dec_cnt <= '0;
        end else begin
          dec_cnt <= dec_cnt + DEC_W'(1);
        end
      end
    end
  end

  // Comb sequencer: walks channels 0..NCH-1 through the shared comb datapath
  // once per hop. comb_stb and busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      comb_ch  <= '0;
      comb_stb <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      comb_stb <= 1'b0;

      case (state)
        S_IDLE: begin
          if (hop) begin
            comb_ch  <= '0;
            comb_stb <= 1'b1;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (comb_done) begin
            if (comb_ch == CH_LAST) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              comb_ch  <= comb_ch + CH_W'(1);
              comb_stb <= 1'b1;
              state    <= S_ISSUE;
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase

      // A hop during a running sequence is dropped but flagged; setting
      // takes priority over a simultaneous clear so no event is lost.
      if (hop && busy) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_sched.sv
// Purpose: directed self-checking bench for pdm_cic_sched (CLK_DIV=8, DECIM=64, NCH=8).
// Latency: outputs sampled on the falling edge after each rising edge; k counts rising edges since enable.
// Backpressure: a small comb datapath model drives comb_done (auto, held-high, or stalled on one channel).

module tb_pdm_cic_sched;

  localparam int NCH = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic           clr_ovr;
  logic [NCH-1:0] din;
  logic           clk_out_pdm;
  logic           sample_stb;
  logic [NCH-1:0] bits;
  logic           hop;
  logic           comb_stb;
  logic [2:0]     comb_ch;
  logic           comb_done;
  logic           busy;
  logic           overrun;

  always #5 clk = ~clk;

  pdm_cic_sched #(.CLK_DIV(8), .DECIM(64), .NCH(NCH)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clr_ovr     (clr_ovr),
    .din         (din),
    .clk_out_pdm (clk_out_pdm),
    .sample_stb  (sample_stb),
    .bits        (bits),
    .hop         (hop),
    .comb_stb    (comb_stb),
    .comb_ch     (comb_ch),
    .comb_done   (comb_done),
    .busy        (busy),
    .overrun     (overrun)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Event log and comb datapath model state.
  int k = 0;
  int stb_k[$];
  int stb_ch[$];
  int hop_k[$];
  int hop_ss[$];
  int busy_cnt = 0;
  int ss_cnt = 0;
  int cnt = 99;
  int stall_ch = -1;
  int stall_len = 0;
  bit hold = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, log what the DUT did, then update the comb model.
  // The model answers comb_done on the second WAIT cycle, or after
  // stall_len cycles for stall_ch, or constantly while hold is set.
  task automatic step();
    @(negedge clk);
    k++;
    if (sample_stb) ss_cnt++;
    if (busy) busy_cnt++;
    if (hop) begin
      hop_k.push_back(k);
      hop_ss.push_back(int'(sample_stb));
    end
    if (comb_stb) begin
      stb_k.push_back(k);
      stb_ch.push_back(int'(comb_ch));
      cnt = (int'(comb_ch) == stall_ch) ? 2 - stall_len : 0;
    end else begin
      cnt++;
    end
    comb_done = hold ? 1'b1 : (cnt == 2);
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic clear_log();
    stb_k.delete();
    stb_ch.delete();
    hop_k.delete();
    hop_ss.delete();
    busy_cnt = 0;
    ss_cnt = 0;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    clr_ovr   = 1'b0;
    din       = '0;
    comb_done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst clk_out_pdm", 32'(clk_out_pdm), 32'd0);
    check_val("rst sample_stb",  32'(sample_stb),  32'd0);
    check_val("rst bits",        32'(bits),        32'd0);
    check_val("rst hop",         32'(hop),         32'd0);
    check_val("rst comb_stb",    32'(comb_stb),    32'd0);
    check_val("rst comb_ch",     32'(comb_ch),     32'd0);
    check_val("rst busy",        32'(busy),        32'd0);
    check_val("rst overrun",     32'(overrun),     32'd0);

    // 1: PDM clock 4 high / 4 low, strobe every 8 clocks, bits capture
    reset  = 1'b0;
    enable = 1'b1;
    din    = 8'hA5;
    for (int j = 1; j <= 24; j++) begin
      step();
      check_val($sformatf("pdm clk k=%0d", k), 32'(clk_out_pdm), 32'(((k - 1) % 8) < 4));
      check_val($sformatf("stb k=%0d", k), 32'(sample_stb), 32'((k % 8) == 0));
      if (k == 8)  check_val("bits first", 32'(bits), 32'h0A5);
      if (k == 12) check_val("bits hold",  32'(bits), 32'h0A5);
      if (k == 16) check_val("bits second", 32'(bits), 32'h03C);
      if (k == 9)  din = 8'h3C;
    end

    // 2+3: first hop at strobe 64, auto comb_done gives 3-clock spacing
    clear_log();
    run_to(600);
    check_val("strobes to 600", 32'(ss_cnt), 32'd72);
    check_val("hop count 1", 32'(hop_k.size()), 32'd1);
    if (hop_k.size() > 0) begin
      check_val("hop1 k", 32'(hop_k[0]), 32'd512);
      check_val("hop1 with stb", 32'(hop_ss[0]), 32'd1);
    end
    check_val("auto stb count", 32'(stb_k.size()), 32'd8);
    for (int i = 0; i < stb_k.size() && i < 8; i++) begin
      check_val($sformatf("auto stb%0d k", i), 32'(stb_k[i]), 32'(513 + 3 * i));
      check_val($sformatf("auto stb%0d ch", i), 32'(stb_ch[i]), 32'(i));
    end
    check_val("auto busy clocks", 32'(busy_cnt), 32'd24);

    // 3b: comb_done held high gives 2-clock spacing
    hold = 1'b1;
    clear_log();
    run_to(1100);
    hold = 1'b0;
    cnt = 99;
    comb_done = 1'b0;
    check_val("hop count 2", 32'(hop_k.size()), 32'd1);
    if (hop_k.size() > 0) check_val("hop2 k", 32'(hop_k[0]), 32'd1024);
    check_val("hold stb count", 32'(stb_k.size()), 32'd8);
    for (int i = 0; i < stb_k.size() && i < 8; i++) begin
      check_val($sformatf("hold stb%0d k", i), 32'(stb_k[i]), 32'(1025 + 2 * i));
      check_val($sformatf("hold stb%0d ch", i), 32'(stb_ch[i]), 32'(i));
    end
    check_val("hold busy clocks", 32'(busy_cnt), 32'd16);

    // 4: stall channel 3 for 600 clocks across the next hop
    clear_log();
    stall_ch = 3;
    stall_len = 600;
    run_to(2048);
    check_val("ovr before hop", 32'(overrun), 32'd0);
    run_to(2049);
    check_val("ovr after hop", 32'(overrun), 32'd1);
    run_to(2100);
    check_val("stall busy", 32'(busy), 32'd1);
    check_val("stall ch", 32'(comb_ch), 32'd3);
    run_to(2200);
    check_val("stall stb count", 32'(stb_k.size()), 32'd8);
    for (int i = 0; i < stb_ch.size() && i < 8; i++) begin
      check_val($sformatf("stall stb%0d ch", i), 32'(stb_ch[i]), 32'(i));
    end
    if (stb_k.size() >= 8) begin
      check_val("stall stb3 k", 32'(stb_k[3]), 32'd1546);
      check_val("stall stb4 k", 32'(stb_k[4]), 32'd2147);
      check_val("stall stb7 k", 32'(stb_k[7]), 32'd2156);
    end
    check_val("stall hops", 32'(hop_k.size()), 32'd2);
    check_val("stall done busy", 32'(busy), 32'd0);
    check_val("ovr sticky", 32'(overrun), 32'd1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check_val("ovr cleared", 32'(overrun), 32'd0);
    stall_ch = -1;

    // 5: enable low for 20 clocks, phase restarts, decimation phase kept
    run_to(2203);
    enable = 1'b0;
    for (int j = 0; j < 20; j++) begin
      step();
      check_val($sformatf("off clk k=%0d", k), 32'(clk_out_pdm), 32'd0);
      check_val($sformatf("off stb k=%0d", k), 32'(sample_stb), 32'd0);
    end
    enable = 1'b1;
    clear_log();
    for (int j = 1; j <= 8; j++) begin
      step();
      check_val($sformatf("resume clk j=%0d", j), 32'(clk_out_pdm), 32'((j - 1) < 4));
      check_val($sformatf("resume stb j=%0d", j), 32'(sample_stb), 32'(j == 8));
    end
    stall_ch = 5;
    stall_len = 1000;
    run_to(2583);
    check_val("resume hop", 32'(hop), 32'd1);
    check_val("resume hop stb", 32'(sample_stb), 32'd1);
    check_val("resume hop count", 32'(hop_k.size()), 32'd1);

    // 6: reset while waiting on channel 5
    run_to(2610);
    check_val("pre-rst busy", 32'(busy), 32'd1);
    check_val("pre-rst ch", 32'(comb_ch), 32'd5);
    reset = 1'b1;
    step();
    check_val("mid-rst busy",        32'(busy),        32'd0);
    check_val("mid-rst comb_ch",     32'(comb_ch),     32'd0);
    check_val("mid-rst overrun",     32'(overrun),     32'd0);
    check_val("mid-rst clk_out_pdm", 32'(clk_out_pdm), 32'd0);
    check_val("mid-rst comb_stb",    32'(comb_stb),    32'd0);
    check_val("mid-rst bits",        32'(bits),        32'd0);
    check_val("mid-rst hop",         32'(hop),         32'd0);
    reset = 1'b0;
    enable = 1'b0;
    stall_ch = -1;
    hold = 1'b1;
    clear_log();
    run_to(2640);
    hold = 1'b0;
    comb_done = 1'b0;
    check_val("late done stb", 32'(stb_k.size()), 32'd0);
    check_val("late done busy", 32'(busy_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
